apb_master_module: RTL and testbench
====================================

# apb_master_module

- APB requester that drives the bus consumed by `APB_interface_module`.
- Accepts one command at a time from a host over a valid/ready channel.
- Runs the APB SETUP and ACCESS phases, honouring wait states and enforcing a timeout.
- Returns read data and error status over a valid/ready response channel.

## Interface
Parameters:
- ADDR_WIDTH, 3, width of paddr/cmd_addr
- DATA_WIDTH, 8, width of pwdata/prdata/cmd_wdata/rsp_rdata
- TIMEOUT_CYCLES, 16, max ACCESS cycles without pready before abort; 0 disables timeout

Ports:
- pclk  in  1  clock; one clock, all logic on rising edge
- preset_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  host command present
- cmd_ready  out  1  block can accept command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target register address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  host takes response
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and for errors)
- rsp_err  out  1  pslverr seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel_x  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready/wait-state
- pslverr  in  1  APB transfer error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Command handshake:
  - cmd_ready = (state == IDLE) && preset_n.
  - Handshake = cmd_valid && cmd_ready.
  - On handshake, capture write/addr/wdata into paddr/pwrite/pwdata; pwdata = 0 for reads. Go to SETUP.
- SETUP: psel_x = 1, penable = 0. Unconditionally go to ACCESS next cycle.
- ACCESS: psel_x = 1, penable = 1. Timeout counter increments each ACCESS cycle with pready = 0.
  - pready = 1:
    - Capture rsp_rdata = prdata for reads, 0 for writes.
    - rsp_err = pslverr; rsp_timeout = 0.
    - If pslverr = 1, rsp_rdata = 0.
    - Go to RESP.
  - Counter reaches TIMEOUT_CYCLES with pready = 0 (TIMEOUT_CYCLES > 0): set rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Go to RESP.
- RESP: psel_x = penable = 0; rsp_valid = 1. Response fields stay stable until rsp_valid && rsp_ready, then go to IDLE.
- No command is accepted in RESP, so there is exactly one outstanding transfer.
- Registers hold stable from SETUP through the final ACCESS cycle: paddr, pwrite, pwdata.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. Counter clears on entry to SETUP.

## Timing
- Reset (preset_n low at an edge):
  - state = IDLE.
  - Outputs zero: psel_x, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, counter.
  - cmd_ready is 0 while preset_n is low.
- Reset mid-transfer: bus drops to idle on the next edge with no response. A pending response is discarded.
- Zero-wait transfer: handshake at edge 0 → SETUP during cycle 1 → ACCESS cycle 2 → rsp_valid high from cycle 3.
- Each wait cycle adds one cycle.
- Back-to-back:
  - rsp_ready already high in the first RESP cycle → IDLE next cycle.
  - A new handshake is possible in that IDLE cycle.
  - Next SETUP follows, giving 4 cycles per transfer minimum.
- Timeout with TIMEOUT_CYCLES = N: the abort takes effect on the edge ending the Nth ACCESS cycle with pready low. rsp_valid is high the cycle after.
- pready and a timeout on the same cycle: pready wins, normal completion.
- pslverr is sampled only when pready = 1 in ACCESS and ignored otherwise.

## Structure
- Shared package apb_pkg:
  - state enum apb_state_e {IDLE, SETUP, ACCESS, RESP};
  - default ADDR_WIDTH/DATA_WIDTH constants, shared with the slave-side modules.
- One sub-module: apb_timeout_counter, with clear, enable, and an expired flag.
- The FSM and datapath registers live in apb_master_module.

## Test plan
- Zero-wait write: cmd addr 3'd1, wdata 8'hA5, pready tied 1 → pwrite = 1, paddr = 1, pwdata = A5 through SETUP/ACCESS. rsp_valid at cycle 3 with rsp_err = 0.
- Read with 2 wait states: prdata = 8'h3C once pready rises → 2 extra ACCESS cycles. rsp_rdata = 3C, rsp_valid at cycle 5.
- Slave error: read addr 3'd7, pready = 1, pslverr = 1 → rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- Timeout: TIMEOUT_CYCLES = 4, pready held 0 → psel_x drops after 4 ACCESS cycles. rsp_err = 1, rsp_timeout = 1.
- Response backpressure and back-to-back:
  - rsp_ready held 0 for 3 cycles → rsp fields stable and cmd_ready = 0.
  - After release, the next queued command is accepted in the following IDLE cycle.
- Reset mid-ACCESS: preset_n low for 1 cycle → psel_x = penable = 0 and rsp_valid = 0 next cycle. cmd_ready = 1 the cycle after preset_n returns high.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states and default bus widths
// common to the master and slave-side modules.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_WIDTH = 3;
    localparam int APB_DATA_WIDTH = 8;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles spent waiting on pready. The expired flag is
// combinational so the abort lands on the edge ending the Nth wait cycle.
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] MAXV  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // Wait-cycle counter: cleared at command acceptance, saturates at the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count < MAXV)) begin
            count <= count + 1'b1;
        end
    end

    // This wait cycle would be the Nth one; zero limit disables the abort
    always_comb begin
        expired = (TIMEOUT_CYCLES > 0) && enable && (count == LIMIT);
    end

endmodule

// File: rtl/apb_master_module.sv
// APB requester: one host command at a time, SETUP/ACCESS sequencing with
// wait states and timeout, response returned over a valid/ready channel.
module apb_master_module
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel_x,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_state_e state;
    logic       handshake;
    logic       wait_cycle;
    logic       expired;

    // Command acceptance only in IDLE and never while reset is asserted
    always_comb begin
        cmd_ready  = (state == IDLE) && preset_n;
        handshake  = cmd_valid && cmd_ready;
        wait_cycle = (state == ACCESS) && !pready;
    end

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (pclk),
        .rst_n   (preset_n),
        .clear   (handshake),
        .enable  (wait_cycle),
        .expired (expired)
    );

    // Transfer FSM with registered bus and response outputs
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state       <= IDLE;
            psel_x      <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        paddr   <= cmd_addr;
                        pwrite  <= cmd_write;
                        pwdata  <= cmd_write ? cmd_wdata : '0;
                        psel_x  <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel_x      <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else if (expired) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        psel_x      <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_module.sv
// Scoreboard bench for apb_master_module with TIMEOUT_CYCLES = 4.
module tb_apb_master_module;

    localparam int TO = 4;

    logic       pclk = 1'b0;
    logic       preset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       psel_x;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       to;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 pclk = ~pclk;

    apb_master_module #(
        .ADDR_WIDTH     (3),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel_x      (psel_x),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Starts and ends at a negedge inside an IDLE cycle.
    task automatic run_xfer(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                            input int waits, input logic [7:0] rd, input logic serr,
                            input int hold);
        rsp_t e;
        rsp_t f;
        int   n_acc;
        bit   tmo;
        tmo   = (waits >= TO);
        n_acc = tmo ? TO : waits + 1;
        e.to    = tmo;
        e.err   = tmo ? 1'b1 : serr;
        e.rdata = (tmo || wr || serr) ? 8'h00 : rd;

        // IDLE: present command
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rsp_valid", rsp_valid, 0);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        pready = 1'b0; pslverr = 1'b0;
        sb.push_back(e);

        // SETUP
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_wdata = ~wd;
        check("setup_psel", psel_x, 1);
        check("setup_penable", penable, 0);
        check("setup_paddr", paddr, a);
        check("setup_pwrite", pwrite, wr);
        check("setup_pwdata", pwdata, wr ? wd : 8'h00);

        // ACCESS cycles; pslverr during wait cycles must be ignored
        for (int i = 0; i < n_acc; i++) begin
            @(negedge pclk);
            check("acc_psel", psel_x, 1);
            check("acc_penable", penable, 1);
            check("acc_paddr", paddr, a);
            check("acc_pwdata", pwdata, wr ? wd : 8'h00);
            check("acc_rsp_valid", rsp_valid, 0);
            if (!tmo && i == waits) begin
                pready = 1'b1; prdata = rd; pslverr = serr;
            end else begin
                pready = 1'b0; prdata = 8'($urandom); pslverr = 1'b1;
            end
        end

        // RESP
        @(negedge pclk);
        pready = 1'b0; pslverr = 1'b0;
        check("resp_psel", psel_x, 0);
        check("resp_penable", penable, 0);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd6; cmd_wdata = 8'hEE;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, e.rdata);
            check("hold_err", rsp_err, e.err);
            check("hold_timeout", rsp_timeout, e.to);
            check("hold_cmd_ready", cmd_ready, 0);
            @(negedge pclk);
            check("hold_psel", psel_x, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        check("resp_valid", rsp_valid, 1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            f = sb.pop_front();
            check("rsp_rdata", rsp_rdata, f.rdata);
            check("rsp_err", rsp_err, f.err);
            check("rsp_timeout", rsp_timeout, f.to);
        end

        // Back in IDLE
        @(negedge pclk);
    endtask

    initial begin
        preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;

        // Reset state
        repeat (2) @(negedge pclk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", psel_x, 0);
        check("rst_penable", penable, 0);
        check("rst_bus", {pwrite, paddr, pwdata}, 0);
        check("rst_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
        preset_n = 1'b1;
        @(negedge pclk);

        run_xfer(1'b1, 3'd1, 8'hA5, 0, 8'h00, 1'b0, 0);   // zero-wait write
        run_xfer(1'b0, 3'd2, 8'h00, 2, 8'h3C, 1'b0, 0);   // read, 2 wait states
        run_xfer(1'b0, 3'd7, 8'h00, 0, 8'h5A, 1'b1, 0);   // slave error on read
        run_xfer(1'b0, 3'd3, 8'h00, 99, 8'h77, 1'b0, 0);  // timeout
        run_xfer(1'b0, 3'd4, 8'h00, TO - 1, 8'hC3, 1'b0, 0); // pready on last allowed cycle
        run_xfer(1'b1, 3'd5, 8'h81, 1, 8'hFF, 1'b1, 0);   // write with slave error
        run_xfer(1'b1, 3'd2, 8'h19, 0, 8'h00, 1'b0, 3);   // response backpressure
        run_xfer(1'b0, 3'd6, 8'h00, 0, 8'h96, 1'b0, 0);   // back-to-back read

        // Reset in the middle of ACCESS: no response expected
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd1;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("mid_acc_penable", penable, 1);
        preset_n = 1'b0;
        @(negedge pclk);
        check("mid_rst_psel", psel_x, 0);
        check("mid_rst_penable", penable, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        preset_n = 1'b1;
        @(negedge pclk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_rsp_valid", rsp_valid, 0);

        run_xfer(1'b0, 3'd0, 8'h00, 1, 8'h42, 1'b0, 0);   // recovery transfer
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
